bcd_para_binario_seq: RTL

- Sequential BCD-to-binary converter; the inverse of the ALU's binary-to-BCD display path.
- Takes three BCD digits (hundreds, tens, units), for example from keypad/switch entry.
- Produces an 8-bit binary operand for the ALU operand registers, with overflow and invalid-digit flags.
- Uses reverse double-dabble: one shift/correct iteration per clock, with a start/busy/done handshake.

---
 rtl/bcd_para_binario_seq_pkg.sv | 22 ++
 rtl/bcd_para_binario_seq_corr_digit.sv | 17 +
 rtl/bcd_para_binario_seq.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/bcd_para_binario_seq_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
package bcd_para_binario_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Largest legal value of one BCD digit
    localparam logic [3:0] DIGIT_MAX   = 4'd9;
    // Reverse double-dabble: after the right shift, a digit that reaches 8
    // carried a borrowed 10 into its top bit; subtracting 3 restores BCD.
    localparam logic [3:0] CORR_THRESH = 4'd8;
    localparam logic [3:0] CORR_SUB    = 4'd3;

    // One shift/correct iteration per BCD bit
    function automatic int iter_count(input int n_digits);
        return 4 * n_digits;
    endfunction

endpackage

// File: rtl/bcd_para_binario_seq_corr_digit.sv
// Per-digit correction used in the CONV datapath: subtract 3 when the digit is >= 8.
module bcd_corr_digit
    import bcd_para_binario_seq_pkg::*;
(
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    // Combinational correction of one 4-bit BCD digit
    always_comb begin
        digit_out = digit_in;
        if (digit_in >= CORR_THRESH) begin
            digit_out = digit_in - CORR_SUB;
        end
    end

endmodule

// File: rtl/bcd_para_binario_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble), one
// shift/correct iteration per clock with a start/busy/done handshake.
module bcd_para_binario_seq
    import bcd_para_binario_seq_pkg::*;
#(
    parameter int N_DIGITS = 3,
    parameter int OUT_W    = 8,
    parameter int ITER     = iter_count(N_DIGITS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       bcd_centenas,
    input  logic [3:0]       bcd_dezenas,
    input  logic [3:0]       bcd_unidades,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] bin_out,
    output logic             LED_OV,
    output logic             LED_ERR
);

    localparam int BCD_W = 4 * N_DIGITS;
    localparam int WORK_W = 2 * BCD_W;
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

    state_t             state_q, state_d;
    logic [WORK_W-1:0]  work_q, work_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [OUT_W-1:0]   bin_out_q, bin_out_d;
    logic               ov_q, ov_d;
    logic               led_err_q, led_err_d;

    logic               digit_bad;
    logic [WORK_W-1:0]  shifted;
    logic [BCD_W-1:0]   corr_bcd;
    logic [WORK_W-1:0]  corrected;

    assign digit_bad = (bcd_centenas > DIGIT_MAX) || (bcd_dezenas > DIGIT_MAX) ||
                       (bcd_unidades > DIGIT_MAX);

    // Shift right by one, then correct every BCD digit of the upper half
    assign shifted = work_q >> 1;

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_corr
        bcd_corr_digit u_corr (
            .digit_in  (shifted[BCD_W + 4*g +: 4]),
            .digit_out (corr_bcd[4*g +: 4])
        );
    end

    assign corrected = {corr_bcd, shifted[BCD_W-1:0]};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = digit_bad ? FIN : CONV;
            CONV: if (cnt_q == CNT_W'(ITER - 1)) state_d = FIN;
            FIN:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values per state
    always_comb begin
        work_d    = work_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        bin_out_d = bin_out_q;
        ov_d      = ov_q;
        led_err_d = led_err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    work_d = {BCD_W'({bcd_centenas, bcd_dezenas, bcd_unidades}), {BCD_W{1'b0}}};
                    cnt_d  = '0;
                    err_d  = digit_bad;
                    busy_d = 1'b1;
                end
            end
            CONV: begin
                work_d = corrected;
                cnt_d  = cnt_q + CNT_W'(1);
            end
            FIN: begin
                done_d    = 1'b1;
                busy_d    = 1'b0;
                led_err_d = err_q;
                if (err_q) begin
                    bin_out_d = '0;
                    ov_d      = 1'b0;
                end else begin
                    bin_out_d = work_q[OUT_W-1:0];
                    ov_d      = |work_q[BCD_W-1:OUT_W];
                end
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers; reset clears everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q    <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bin_out_q <= '0;
            ov_q      <= 1'b0;
            led_err_q <= 1'b0;
        end else begin
            work_q    <= work_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bin_out_q <= bin_out_d;
            ov_q      <= ov_d;
            led_err_q <= led_err_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bin_out = bin_out_q;
    assign LED_OV  = ov_q;
    assign LED_ERR = led_err_q;

endmodule
